id_exe_pipe_stage: RTL and testbench
====================================

// Module: id_exe_pipe_stage
// PURPOSE
//   Elastic ID->EXE pipeline stage for the 5-stage core. Replaces the fixed
//   PC/instruction register pair with a valid/ready stage holding the full
//   decode payload. A 2-entry skid buffer lets EXE stall without a
//   combinational ready path back into ID. It supports synchronous flush
//   (bubble insertion) and counts bubble cycles for performance monitoring.
// PARAMETERS
//   LEN        32  PC / instruction width
//   DATA_W     32  reg2, alu_inp1, alu_inp2 width
//   REG_ADDR_W  5  dest register address width
//   EXE_CMD_W   4  exe_cmd width
//   CNT_W      16  bubble_count width
// PORTS
//   clock          in   1          rising-edge clock
//   reset          in   1          asynchronous, active-low reset
//   in_valid       in   1          ID presents a beat
//   in_ready       out  1          stage accepts a beat this cycle
//   pc, instruction              in  LEN         decode payload
//   wb_en, mem_read, mem_write   in  1 each      control payload
//   branch_type    in   2          control payload
//   exe_cmd        in   EXE_CMD_W  control payload
//   reg2, alu_inp1, alu_inp2     in  DATA_W      operand payload
//   dest           in   REG_ADDR_W destination register
//   flush          in   1          kill all held beats and the incoming beat
//   out_valid      out  1          EXE-side beat valid
//   out_ready      in   1          EXE consumes a beat
//   <field>_out    out  as input   registered copy of every payload field
//   bubble_count   out  CNT_W      saturating count of cycles with out_valid=0
// BEHAVIOUR
//   - Reset (reset=0, async): main_v=skid_v=0; all *_out=0; bubble_count=0;
//     out_valid=0. in_ready=1, because in_ready is driven as !skid_v from a flop.
//   - Accept: acc = in_valid & in_ready. Pop: pop = out_valid & out_ready.
//   - Latency: an accepted beat reaches *_out on the next edge when main is
//     empty or popping. Otherwise it parks in skid. Order is always preserved.
//   - Per edge, without flush:
//       main empty or pop, skid_v=1 : main<=skid; skid<=in if acc, else skid_v<=0
//       main empty or pop, skid_v=0 : main<=in if acc, else main_v<=0
//       main full, no pop           : skid<=in if acc; main holds
//   - in_ready deasserts when skid_v=1. A beat presented then is not consumed,
//     and ID must hold it.
//   - flush=1 (sync, highest priority): main_v<=0, skid_v<=0, and the
//     incoming beat is dropped even if in_valid & in_ready.
//   - out_valid = main_v. While main_v=0, wb_en_out, mem_read_out,
//     mem_write_out and branch_type_out read 0 (NOP bubble). Other *_out hold
//     their last value and are don't-care.
//   - A flush on the same edge as a pop: the popped beat counts as consumed,
//     and nothing remains.
//   - bubble_count: +1 on each edge where out_valid=0. Saturates at
//     2^CNT_W-1 and never wraps. It is not cleared by flush.
//   - No arithmetic on the payload. All fields are copied bit-exactly.
// STRUCTURE
//   - id_exe_pkg holds the width localparams and the id_exe_payload_t packed
//     struct (pc, instruction, wb_en, mem_read, mem_write, branch_type,
//     exe_cmd, reg2, alu_inp1, alu_inp2, dest) plus a PAYLOAD_NOP constant.
//   - Sub-module pipe_slot #(W) is instantiated twice (main, skid). It holds
//     payload and valid, with load/clear inputs and async active-low reset.
//   - The top level holds the steering mux, the in_ready flop and the
//     bubble counter.
// TESTING
//   1. Reset mid-traffic: drive reset=0 async between edges. All outputs go
//      to 0 immediately, in_ready=1, and bubble_count=0.
//   2. Streaming with out_ready=1: send pc=0x00,0x04,0x08 back-to-back. The
//      same pcs appear on consecutive cycles, each one cycle later, and
//      in_ready stays 1.
//   3. Stall: out_ready=0 for 3 cycles while ID sends pc 0x10,0x14,0x18.
//      0x10 is held, 0x14 goes to skid, and in_ready=0 holds 0x18. After
//      release, the order is 0x10,0x14,0x18 with no loss or duplication.
//   4. Flush: with main and skid full, assert flush plus in_valid (pc=0x40).
//      Next cycle out_valid=0, wb_en_out=mem_write_out=0, and 0x40 never
//      appears.
//   5. Flush+pop: out_ready=1 and flush=1 on the same edge. The main beat is
//      consumed once and the stage is empty afterwards.
//   6. Counter saturation with CNT_W=4: hold in_valid=0 for 20 cycles.
//      bubble_count reaches 15 and stays there.

Source files
------------

// File: rtl/id_exe_pkg.sv
// Shared widths and the decode payload carried from ID into EXE.
// PAYLOAD_NOP is the all-zero payload that EXE treats as a bubble.
package id_exe_pkg;
  localparam int LEN          = 32;
  localparam int DATA_W       = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int EXE_CMD_W    = 4;
  localparam int BUBBLE_CNT_W = 16;

  typedef struct packed {
    logic [LEN-1:0]        pc;
    logic [LEN-1:0]        instruction;
    logic                  wb_en;
    logic                  mem_read;
    logic                  mem_write;
    logic [1:0]            branch_type;
    logic [EXE_CMD_W-1:0]  exe_cmd;
    logic [DATA_W-1:0]     reg2;
    logic [DATA_W-1:0]     alu_inp1;
    logic [DATA_W-1:0]     alu_inp2;
    logic [REG_ADDR_W-1:0] dest;
  } id_exe_payload_t;

  localparam int PL_W = $bits(id_exe_payload_t);
  localparam id_exe_payload_t PAYLOAD_NOP = '0;

  // Strip the side-effecting controls so a stale payload behaves as a NOP.
  function automatic id_exe_payload_t to_bubble(id_exe_payload_t p);
    id_exe_payload_t b;
    b             = p;
    b.wb_en       = 1'b0;
    b.mem_read    = 1'b0;
    b.mem_write   = 1'b0;
    b.branch_type = 2'b00;
    return b;
  endfunction
endpackage

// File: rtl/id_exe_pipe_stage_if.sv
// ID->EXE handshake bundle: ID-side request, EXE-side response, flush and
// the bubble counter. The stage uses the slave view.
interface id_exe_pipe_stage_if
  import id_exe_pkg::*;
#(
    parameter int CNT_W = BUBBLE_CNT_W
);
    logic             in_valid;
    logic             in_ready;
    id_exe_payload_t  in_pl;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    id_exe_payload_t  out_pl;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output in_valid, in_pl, flush, out_ready,
        input  in_ready, out_valid, out_pl, bubble_count
    );
    modport slave (
        input  in_valid, in_pl, flush, out_ready,
        output in_ready, out_valid, out_pl, bubble_count
    );
endinterface

// File: rtl/id_exe_pipe_stage_pipe_slot.sv
// One payload register plus its valid bit. Clear wins over load.
module pipe_slot #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         v
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
            v <= 1'b0;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            q <= d;
            v <= 1'b1;
        end
    end
endmodule

// File: rtl/id_exe_pipe_stage.sv
// Elastic ID->EXE stage: main slot drives EXE, skid slot absorbs one beat
// while EXE stalls so in_ready comes from a flop, not from out_ready.
module id_exe_pipe_stage
  import id_exe_pkg::*;
#(
    parameter int CNT_W = BUBBLE_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    id_exe_pipe_stage_if.slave   bus
);
    logic            main_v, skid_v, in_ready_q;
    logic [PL_W-1:0] main_q, skid_q, main_d;
    logic            main_ld, main_clr, skid_ld, skid_clr;
    logic            acc, pop, main_free, skid_v_nxt;
    logic [CNT_W-1:0] cnt_q;

    assign acc       = bus.in_valid & in_ready_q;
    assign pop       = main_v & bus.out_ready;
    assign main_free = ~main_v | pop;

    always_comb begin
        main_ld  = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        main_d   = bus.in_pl;
        if (bus.flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (main_free) begin
            if (skid_v) begin
                // Skid is older than anything on the input, so it goes first.
                main_ld  = 1'b1;
                main_d   = skid_q;
                skid_ld  = acc;
                skid_clr = ~acc;
            end else begin
                main_ld  = acc;
                main_clr = ~acc;
            end
        end else begin
            skid_ld = acc;
        end
    end

    assign skid_v_nxt = ~bus.flush & (skid_ld | (skid_v & ~skid_clr));

    pipe_slot #(.W(PL_W)) u_main (
        .clock (clock), .reset (reset), .load (main_ld), .clear (main_clr),
        .d (main_d), .q (main_q), .v (main_v)
    );

    pipe_slot #(.W(PL_W)) u_skid (
        .clock (clock), .reset (reset), .load (skid_ld), .clear (skid_clr),
        .d (bus.in_pl), .q (skid_q), .v (skid_v)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) in_ready_q <= 1'b1;
        else        in_ready_q <= ~skid_v_nxt;
    end

    // Saturating bubble counter; flush does not clear it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     cnt_q <= '0;
        else if (!main_v && ~&cnt_q)    cnt_q <= cnt_q + 1'b1;
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = main_v;
    assign bus.out_pl       = main_v ? id_exe_payload_t'(main_q)
                                     : to_bubble(id_exe_payload_t'(main_q));
    assign bus.bubble_count = cnt_q;
endmodule

// File: tb/tb_id_exe_pipe_stage.sv
// Scoreboard bench: the stage is modelled as a 2-deep FIFO; directed phases
// cover streaming, stall, flush, flush+pop, reset and counter saturation.
module tb_id_exe_pipe_stage;
  import id_exe_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  id_exe_pipe_stage_if #(.CNT_W(4)) bus ();
  id_exe_pipe_stage #(.CNT_W(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  id_exe_payload_t exp_q[$];
  int              bc_exp = 0;
  logic [31:0]     dut_log[$];
  bit              m_acc, m_pop;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference: a FIFO of at most two beats; flush empties it.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      bc_exp = 0;
    end else begin
      m_acc = bus.in_valid && exp_q.size() < 2;
      m_pop = exp_q.size() > 0 && bus.out_ready;
      if (exp_q.size() == 0 && bc_exp < 15) bc_exp++;
      if (bus.flush) exp_q.delete();
      else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_acc) exp_q.push_back(bus.in_pl);
      end
    end
  end

  // Monitor: inputs change at posedge+1, so negedge sees stable state.
  always @(negedge clock) begin
    if (reset) begin
      chk("out_valid", bus.out_valid, exp_q.size() > 0);
      chk("in_ready", bus.in_ready, exp_q.size() < 2);
      chk("bubble_count", bus.bubble_count, bc_exp);
      if (exp_q.size() > 0) begin
        chk("payload", bus.out_pl, exp_q[0]);
        if (bus.out_ready) dut_log.push_back(bus.out_pl.pc);
      end else begin
        chk("nop_ctrl", {bus.out_pl.wb_en, bus.out_pl.mem_read,
                         bus.out_pl.mem_write, bus.out_pl.branch_type}, 5'b0);
      end
    end
  end

  function automatic id_exe_payload_t rpl(logic [31:0] pc);
    id_exe_payload_t p;
    p.pc          = pc;
    p.instruction = $urandom;
    p.wb_en       = 1'($urandom);
    p.mem_read    = 1'($urandom);
    p.mem_write   = 1'($urandom);
    p.branch_type = 2'($urandom);
    p.exe_cmd     = 4'($urandom);
    p.reg2        = $urandom;
    p.alu_inp1    = $urandom;
    p.alu_inp2    = $urandom;
    p.dest        = 5'($urandom);
    return p;
  endfunction

  task automatic cyc(bit v, id_exe_payload_t pl, bit ordy, bit fl);
    @(posedge clock);
    #1;
    bus.in_valid  = v;
    bus.in_pl     = pl;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // Present a beat and hold it until the stage takes it (bounded).
  task automatic send(logic [31:0] pc, bit ordy);
    id_exe_payload_t p;
    bit done;
    p    = rpl(pc);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc(1'b1, p, ordy, 1'b0);
      done = bus.in_ready;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=in_ready_low want=accept pc=%0h", pc);
    end
  endtask

  task automatic idle(int n, bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, rpl(32'hdead), ordy, 1'b0);
  endtask

  task automatic chk3(string nm, int a, int b, int c);
    int e[3];
    e = '{a, b, c};
    chk({nm, "_n"}, dut_log.size(), 3);
    if (dut_log.size() == 3)
      for (int i = 0; i < 3; i++) chk(nm, dut_log[i], e[i]);
  endtask

  initial begin
    id_exe_payload_t p;
    bus.in_valid  = 1'b0;
    bus.in_pl     = PAYLOAD_NOP;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // streaming
    dut_log.delete();
    send(32'h00, 1'b1);
    send(32'h04, 1'b1);
    send(32'h08, 1'b1);
    idle(3, 1'b1);
    chk3("stream_order", 32'h00, 32'h04, 32'h08);

    // stall with skid fill, then release
    dut_log.delete();
    cyc(1'b1, rpl(32'h10), 1'b0, 1'b0);
    cyc(1'b1, rpl(32'h14), 1'b0, 1'b0);
    cyc(1'b1, rpl(32'h18), 1'b0, 1'b0);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    send(32'h18, 1'b1);
    idle(4, 1'b1);
    chk3("stall_order", 32'h10, 32'h14, 32'h18);

    // flush with both slots full and a beat on the input
    dut_log.delete();
    cyc(1'b1, rpl(32'h20), 1'b0, 1'b0);
    p = rpl(32'h24); p.wb_en = 1'b1; p.mem_write = 1'b1;
    cyc(1'b1, p, 1'b0, 1'b0);
    cyc(1'b1, rpl(32'h40), 1'b0, 1'b1);
    cyc(1'b0, rpl(32'h0), 1'b0, 1'b0);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_wb_mw", {bus.out_pl.wb_en, bus.out_pl.mem_write}, 2'b00);
    idle(3, 1'b1);
    chk("flush_nothing_out", dut_log.size(), 0);

    // flush on the same edge as a pop
    dut_log.delete();
    cyc(1'b1, rpl(32'h50), 1'b0, 1'b0);
    cyc(1'b0, rpl(32'h0), 1'b1, 1'b1);
    cyc(1'b0, rpl(32'h0), 1'b1, 1'b0);
    chk("fpop_empty", bus.out_valid, 1'b0);
    idle(2, 1'b1);
    chk("fpop_n", dut_log.size(), 1);
    if (dut_log.size() == 1) chk("fpop_pc", dut_log[0], 32'h50);

    // counter saturation
    idle(20, 1'b1);
    chk("bubble_sat", bus.bubble_count, 4'd15);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, rpl($urandom), ($urandom % 3) != 0,
          ($urandom % 20) == 0);

    // asynchronous reset between edges while traffic is held
    cyc(1'b1, rpl(32'h60), 1'b0, 1'b0);
    cyc(1'b1, rpl(32'h64), 1'b0, 1'b0);
    @(posedge clock);
    #2 reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_bubble", bus.bubble_count, 4'd0);
    chk("rst_payload", bus.out_pl, PAYLOAD_NOP);
    @(posedge clock);
    #1 reset = 1'b1;
    idle(3, 1'b1);
    chk("rst_bubble_after", bus.bubble_count, 4'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
